// File: rtl/fetch_unit_pkg.sv
// Shared types, constants and helpers for the instruction-fetch stage.
package fetch_unit_pkg;

  typedef logic        u1;
  typedef logic [5:0]  u6;
  typedef logic [31:0] u32;

  localparam int INST_W           = 32;
  localparam u32 RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  function automatic u32 align_word(input u32 addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter and latched request address, with redirect/increment selection.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter u32 RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        incr,
  input  logic        load_req,
  output logic [31:0] pc,
  output logic [31:0] pc_inc,
  output logic [31:0] req_addr
);

  u32 pc_next;

  assign pc_inc = pc + 32'd4;

  // Redirect wins over sequential increment; otherwise the PC holds.
  always_comb begin
    pc_next = pc;
    if (redirect_valid)
      pc_next = align_word(redirect_pc);
    else if (incr)
      pc_next = pc_inc;
  end

  // req_addr takes the value the PC is about to hold, so a request opened
  // by a redirect already points at the target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      pc <= pc_next;
      if (load_req)
        req_addr <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, imem req/ack handshake, and a
// one-entry valid/ready hold register toward the decoder.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter u32 RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic [31:0]       pc_plus4
);

  fetch_state_e state, state_next;
  u32 pc, pc_inc, req_addr;
  u1  incr, load_req;

  assign incr     = (state == FETCH) && imem_ack && !redirect_valid;
  assign load_req = (state_next == FETCH);

  fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .incr           (incr),
    .load_req       (load_req),
    .pc             (pc),
    .pc_inc         (pc_inc),
    .req_addr       (req_addr)
  );

  // A request stays open in DROP so memory still completes the handshake.
  assign imem_req   = (state == FETCH) || (state == DROP);
  assign imem_addr  = req_addr;
  assign inst_valid = (state == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= BOOT;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:  state_next = FETCH;
      FETCH: begin
        if (redirect_valid)
          state_next = imem_ack ? FETCH : DROP;
        else if (imem_ack)
          state_next = HOLD;
      end
      HOLD:  if (redirect_valid || inst_ready) state_next = FETCH;
      DROP:  if (imem_ack) state_next = FETCH;
      default: state_next = BOOT;
    endcase
  end

  // Hold registers only load on an accepted, un-squashed fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst     <= '0;
      inst_pc  <= '0;
      pc_plus4 <= '0;
    end else if (incr) begin
      inst     <= imem_rdata;
      inst_pc  <= pc;
      pc_plus4 <= pc_inc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot sequence, backpressure, redirects,
// slow memory, PC wrap and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, ack_en;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc, pc_plus4;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_inst, w_inst_pc, w_pc_plus4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory returns an address-tagged word; ack is gated by the bench.
  assign imem_ack   = imem_req && ack_en;
  assign imem_rdata = 32'hC000_0000 | imem_addr;
  assign w_rdata    = 32'hC000_0000 | w_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .pc_plus4(pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(w_valid), .inst_ready(1'b1),
    .inst(w_inst), .inst_pc(w_inst_pc), .pc_plus4(w_pc_plus4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ack_en = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_w_addr", w_addr, 32'hFFFF_FFFC);

    // Boot with zero-wait memory
    reset = 1'b0;
    tick();
    chk("boot_req", {31'b0, imem_req}, 32'd1);
    chk("boot_addr0", imem_addr, 32'h0);
    chk("boot_valid0", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("seq_valid0", {31'b0, inst_valid}, 32'd1);
    chk("seq_req_in_hold", {31'b0, imem_req}, 32'd0);
    chk("seq_inst0", inst, 32'hC000_0000);
    chk("seq_pc0", inst_pc, 32'h0);
    chk("seq_p4_0", pc_plus4, 32'h4);
    chk("wrap_pc0", w_inst_pc, 32'hFFFF_FFFC);
    chk("wrap_p4_0", w_pc_plus4, 32'h0);
    tick();
    chk("seq_addr1", imem_addr, 32'h4);
    chk("seq_valid_gap", {31'b0, inst_valid}, 32'd0);
    chk("wrap_addr1", w_addr, 32'h0);
    tick();
    chk("seq_pc1", inst_pc, 32'h4);
    chk("seq_p4_1", pc_plus4, 32'h8);
    tick();
    chk("seq_addr2", imem_addr, 32'h8);
    inst_ready = 1'b0;
    tick();
    chk("seq_pc2", inst_pc, 32'h8);
    chk("seq_p4_2", pc_plus4, 32'hC);
    chk("seq_inst2", inst, 32'hC000_0008);

    // Backpressure: hold for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_req", {31'b0, imem_req}, 32'd0);
      chk("bp_pc", inst_pc, 32'h8);
      chk("bp_inst", inst, 32'hC000_0008);
    end
    inst_ready = 1'b1;
    tick();
    chk("bp_release_req", {31'b0, imem_req}, 32'd1);
    chk("bp_release_addr", imem_addr, 32'hC);
    tick();
    chk("pre_redir_pc", inst_pc, 32'hC);

    // Redirect while holding: squash regardless of ready
    inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    tick();
    redirect_valid = 1'b0;
    chk("redir_hold_valid", {31'b0, inst_valid}, 32'd0);
    chk("redir_hold_addr", imem_addr, 32'h40);
    chk("redir_hold_req", {31'b0, imem_req}, 32'd1);

    // Slow memory with a redirect while the request is pending
    ack_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("drop_req0", {31'b0, imem_req}, 32'd1);
    chk("drop_addr0", imem_addr, 32'h40);
    chk("drop_valid0", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("drop_addr1", imem_addr, 32'h40);
    chk("drop_valid1", {31'b0, inst_valid}, 32'd0);
    ack_en = 1'b1;
    tick();
    chk("drop_done_req", {31'b0, imem_req}, 32'd1);
    chk("drop_done_addr", imem_addr, 32'h100);
    chk("drop_done_valid", {31'b0, inst_valid}, 32'd0);
    inst_ready = 1'b1;
    tick();
    chk("target_valid", {31'b0, inst_valid}, 32'd1);
    chk("target_pc", inst_pc, 32'h100);
    chk("target_inst", inst, 32'hC000_0100);

    // Reset asserted while a request is outstanding
    tick();
    chk("mid_addr", imem_addr, 32'h104);
    ack_en = 1'b0;
    tick();
    chk("mid_req", {31'b0, imem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_req", {31'b0, imem_req}, 32'd0);
    chk("async_valid", {31'b0, inst_valid}, 32'd0);
    chk("async_inst_pc", inst_pc, 32'h0);
    tick(); tick();
    reset = 1'b0; ack_en = 1'b1;
    tick();
    chk("rerun_req", {31'b0, imem_req}, 32'd1);
    chk("rerun_addr", imem_addr, 32'h0);
    tick();
    chk("rerun_pc", inst_pc, 32'h0);
    chk("rerun_valid", {31'b0, inst_valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS core. It sits directly upstream of the main decoder. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds each fetched instruction with a valid/ready handshake until the decode stage accepts it. Taken branches and jumps from the execute side redirect the PC and squash any instruction in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset; low two bits must be 0.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: read request to instruction memory.
- `imem_addr` out 32: word-aligned fetch address; stable while `imem_req` is high.
- `imem_ack` in 1: read data valid this cycle; only meaningful while `imem_req` is high.
- `imem_rdata` in 32: instruction word, sampled when `imem_ack` is high.
- `redirect_valid` in 1: one-cycle pulse for a taken branch or jump.
- `redirect_pc` in 32: target PC; bits [1:0] are ignored and forced to 0.
- `inst_valid` out 1: `inst` is valid for the decoder.
- `inst_ready` in 1: decoder accepts `inst` this cycle.
- `inst` out 32: instruction word; the decoder takes op from [31:26].
- `inst_pc` out 32: PC of `inst`.
- `pc_plus4` out 32: `inst_pc` + 4, used for branch and jump target formation.

## Operation
- Internal state:
  - `pc` register;
  - FSM with states BOOT, FETCH, HOLD, DROP;
  - output registers for `inst`, `inst_pc` and `pc_plus4`.
- Combinational outputs:
  - `imem_req` = (state == FETCH);
  - `imem_addr` = `pc`;
  - `inst_valid` = (state == HOLD).
- BOOT: entered on reset; moves to FETCH unconditionally on the next edge.
- FETCH, on `imem_ack` with no redirect:
  - `inst` <= `imem_rdata`, `inst_pc` <= `pc`, `pc_plus4` <= `pc` + 4;
  - `pc` <= `pc` + 4;
  - go to HOLD.
- FETCH with no ack: stay in FETCH, hold `pc` unchanged.
- HOLD with `inst_ready`: go to FETCH. Otherwise stay; `inst`, `inst_pc` and `pc_plus4` remain stable.
- DROP: a request was outstanding when a redirect arrived. Wait for `imem_ack`, discard the data, then go to FETCH. `imem_req` stays low in DROP, but memory is still owed the ack.
  - Correction: `imem_req` must stay high in DROP so the handshake completes. `imem_req` = state ∈ {FETCH, DROP}.
  - `imem_addr` in DROP is the old address, held in a separate `req_addr` register latched at request start. `imem_addr` = `req_addr`.
- Redirect (`redirect_valid` = 1) has priority over everything else:
  - `pc` <= {`redirect_pc`[31:2], 2'b00}.
  - From HOLD: the held instruction is squashed; go to FETCH regardless of `inst_ready`.
  - From FETCH with `imem_ack` the same cycle: data discarded; go to FETCH.
  - From FETCH without ack: go to DROP.
  - From DROP: retarget `pc` and stay in DROP until the ack.
  - From BOOT: `pc` takes the redirect target; go to FETCH.
- `req_addr` <= `pc` on every entry into FETCH (including the BOOT→FETCH transition), so the address is constant for the whole request.
- Arithmetic: PC increment is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - state = BOOT;
  - `pc` = `req_addr` = `RESET_PC`;
  - `imem_req` = 0, `inst_valid` = 0;
  - `inst` = 0, `inst_pc` = 0, `pc_plus4` = 0.
- First `imem_req` is asserted in the first cycle after the edge that sees `reset` low.
- Latency with zero-wait memory (ack in the same cycle as req):
  - `inst_valid` rises one cycle after the ack;
  - sustained throughput is one instruction per 2 cycles with `inst_ready` held high.
- A redirect in cycle N causes `imem_addr` = target no later than cycle N+1, or one cycle after the pending ack if a request was in flight.
- Reset mid-operation: immediate return to BOOT. Any outstanding memory request is abandoned; instruction memory must also reset on `reset`.

## Structure
- Add to `common.svh`:
  - state enum `fetch_state_e`;
  - `` `INST_W `` (32);
  - `` `RESET_PC_DEFAULT ``.
- Use the existing `u1`/`u6`/`u32` typedefs from `common.svh`.
- One natural sub-module: `pc_reg`, which holds `pc` and `req_addr` with async reset and the redirect/increment mux. The FSM and instruction hold registers live in `fetch_unit`.

## Test plan
- Reset release with `RESET_PC` = 0 and memory acking every request immediately:
  - `imem_addr` sequence 0, 4, 8;
  - `inst_valid` pulses every 2nd cycle with `inst_pc` 0, 4, 8 and `pc_plus4` 4, 8, 12.
- Backpressure: `inst_ready` = 0 for 5 cycles while in HOLD → `inst` and `inst_pc` stay stable, `imem_req` stays 0. Raising `inst_ready` → next request at the next address.
- Redirect in HOLD: `redirect_pc` = 32'h0000_0043 → held instruction dropped, next `imem_addr` = 32'h0000_0040, and no `inst_valid` for the squashed word.
- Redirect while waiting on a 3-cycle memory → `imem_addr` stays at the old address until its ack, that data is never presented, then a request is issued at the target.
- PC wrap: `RESET_PC` = 32'hFFFF_FFFC → second fetch address is 32'h0000_0000 and `pc_plus4` of the first instruction is 0.
- Reset asserted mid-request → `imem_req` and `inst_valid` drop immediately; after release, the first fetch is at `RESET_PC`.
